// File: rtl/intc_pkg.sv
// Shared definitions for the external interrupt controller: FSM encoding,
// register addresses and cause-word construction.
package intc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } intc_state_e;

    localparam logic [1:0]  ADDR_PENDING      = 2'd0;
    localparam logic [1:0]  ADDR_MASK         = 2'd1;
    localparam logic [1:0]  ADDR_STATUS       = 2'd2;
    localparam logic [1:0]  ADDR_EOI          = 2'd3;
    localparam logic [31:0] CAUSE_EXT_DEFAULT = 32'h0000_0080;

    function automatic logic [31:0] make_cause(input logic [31:0] base, input logic [4:0] id);
        return base | {27'd0, id};
    endfunction

endpackage

// File: rtl/irq_sync_edge.sv
// One interrupt line: multi-flop synchroniser followed by a history flop
// that turns each synchronised rising edge into a single-cycle pulse.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   hist_r;

    // Synchroniser shift chain and edge-history flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            hist_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], irq};
            hist_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign rise = sync_r[SYNC_STAGES-1] & ~hist_r;

endmodule

// File: rtl/ext_interrupt_controller.sv
// Fixed-priority external interrupt controller feeding the Coprocessor0
// interrupt mux, with PENDING/MASK/STATUS/EOI registers on the MMU port.
module ext_interrupt_controller
    import intc_pkg::*;
#(
    parameter int          NUM_IRQ     = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] CAUSE_EXT   = CAUSE_EXT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               int_en,
    input  logic               inte_accept,
    input  logic               reg_we,
    input  logic [1:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               out_inte,
    output logic [31:0]        out_cause
);

    intc_state_e        state_r;
    logic [4:0]         cur_id_r;
    logic [NUM_IRQ-1:0] pending_r;
    logic [NUM_IRQ-1:0] mask_r;
    logic [NUM_IRQ-1:0] rise_s;
    logic [NUM_IRQ-1:0] active_s;
    logic [NUM_IRQ-1:0] pending_nxt_s;
    logic [NUM_IRQ-1:0] accept_clr_s;
    logic [4:0]         winner_s;
    logic [31:0]        rdata_s;
    logic               w1c_we_s;
    logic               mask_we_s;
    logic               eoi_we_s;
    logic               accept_s;
    logic               unused_wdata_s;

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_line
        irq_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk  (clk),
            .rst_n(rst_n),
            .irq  (irq_in[g]),
            .rise (rise_s[g])
        );
    end

    assign active_s       = pending_r & mask_r;
    assign w1c_we_s       = reg_we && (reg_addr == ADDR_PENDING);
    assign mask_we_s      = reg_we && (reg_addr == ADDR_MASK);
    assign eoi_we_s       = reg_we && (reg_addr == ADDR_EOI);
    assign accept_s       = (state_r == ST_REQ) && inte_accept;
    assign accept_clr_s   = NUM_IRQ'(1'b1) << cur_id_r;
    assign unused_wdata_s = ^reg_wdata;

    // Lowest set index wins: scan downward so the last hit is the smallest.
    always_comb begin
        winner_s = 5'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            winner_s = active_s[i] ? 5'(i) : winner_s;
        end
    end

    // Pending update: W1C and accept clear first, a new edge then sets and wins.
    always_comb begin
        pending_nxt_s = pending_r;
        if (w1c_we_s) begin
            pending_nxt_s = pending_nxt_s & ~reg_wdata[NUM_IRQ-1:0];
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        if (accept_s) begin
            pending_nxt_s = pending_nxt_s & ~accept_clr_s;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
        pending_nxt_s = pending_nxt_s | rise_s;
    end

    // Register file state and the request/service state machine.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cur_id_r  <= 5'd0;
            pending_r <= {NUM_IRQ{1'b0}};
            mask_r    <= {NUM_IRQ{1'b0}};
        end else begin
            pending_r <= pending_nxt_s;
            if (mask_we_s) begin
                mask_r <= reg_wdata[NUM_IRQ-1:0];
            end
            case (state_r)
                ST_IDLE: begin
                    if (|active_s) begin
                        cur_id_r <= winner_s;
                        state_r  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (inte_accept) begin
                        state_r <= ST_SERVICE;
                    end
                end
                ST_SERVICE: begin
                    if (eoi_we_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Register read mux; unused bits read as zero.
    always_comb begin
        rdata_s = 32'd0;
        case (reg_addr)
            ADDR_PENDING: rdata_s[NUM_IRQ-1:0] = pending_r;
            ADDR_MASK:    rdata_s[NUM_IRQ-1:0] = mask_r;
            ADDR_STATUS: begin
                rdata_s[9:8] = state_r;
                rdata_s[4:0] = cur_id_r;
            end
            ADDR_EOI:     rdata_s = 32'd0;
            default:      rdata_s = 32'd0;
        endcase
    end

    // The enable gates the request live so it can drop and return without touching state.
    assign reg_rdata = rdata_s;
    assign out_inte  = (state_r == ST_REQ) && int_en;
    assign out_cause = make_cause(CAUSE_EXT, cur_id_r);

endmodule
